// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer sharing one memory between the CPU (port 0) and a secondary master.
// Serialises accesses with a fixed memory latency and returns a one-cycle ready pulse.
module mem_arbiter #(
  parameter int unsigned MEM_LAT     = 1,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  be0,
  input  logic [3:0]  be1,
  input  logic        sign0,
  input  logic        sign1,
  output logic        ready0,
  output logic        ready1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic        mem_sign,
  input  logic [31:0] mem_dout,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  localparam logic [3:0] CntInit = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        cmd_we_q;
  logic [31:0] cmd_addr_q;
  logic [31:0] cmd_wdata_q;
  logic [3:0]  cmd_be_q;
  logic        cmd_sign_q;
  logic        grant_q;
  logic        last_grant_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic        any_req;
  logic        grant_sel;

  // A lone request wins; on a tie, round-robin favours the port not granted last.
  always_comb begin
    any_req   = req0 | req1;
    grant_sel = ~req0;
    if (req0 && req1) begin
      grant_sel = ROUND_ROBIN ? ~last_grant_q : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StBusy;
      StBusy:  if (cnt_q == 4'd0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 4'd0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= 32'd0;
      cmd_wdata_q  <= 32'd0;
      cmd_be_q     <= 4'd0;
      cmd_sign_q   <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            cnt_q        <= CntInit;
            grant_q      <= grant_sel;
            last_grant_q <= grant_sel;
            cmd_we_q     <= grant_sel ? we1    : we0;
            cmd_addr_q   <= grant_sel ? addr1  : addr0;
            cmd_wdata_q  <= grant_sel ? wdata1 : wdata0;
            cmd_be_q     <= grant_sel ? be1    : be0;
            cmd_sign_q   <= grant_sel ? sign1  : sign0;
          end
        end
        StBusy: begin
          if (cnt_q == 4'd0) begin
            if (!cmd_we_q) begin
              if (grant_q) rdata1_q <= mem_dout;
              else         rdata0_q <= mem_dout;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write strobe only in the first BUSY cycle, identified by the untouched counter.
  always_comb begin
    busy     = (state_q != StIdle);
    ready0   = (state_q == StResp) && !grant_q;
    ready1   = (state_q == StResp) && grant_q;
    mem_we   = (state_q == StBusy) && cmd_we_q && (cnt_q == CntInit);
    mem_addr = cmd_addr_q;
    mem_din  = cmd_wdata_q;
    mem_be   = cmd_be_q;
    mem_sign = cmd_sign_q;
    grant_id = grant_q;
    rdata0   = rdata0_q;
    rdata1   = rdata1_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: two instances (MEM_LAT=1 round-robin, MEM_LAT=3 fixed
// priority), each checked against a transaction-level model with its own reference memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit done [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", tag, got, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned Lat = (g == 0) ? 1 : 3;
    localparam bit          Rr  = (g == 0);

    logic        rst;
    logic [1:0]  req, we, sign;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    logic        ready0, ready1, mem_we, mem_sign, busy, grant_id;
    logic [31:0] rdata0, rdata1, mem_addr, mem_din, mem_dout;
    logic [3:0]  mem_be;
    logic [31:0] dmem [64];
    logic [31:0] rmem [64];

    mem_arbiter #(.MEM_LAT(Lat), .ROUND_ROBIN(Rr)) dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
      .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
      .be0(be[0]), .be1(be[1]), .sign0(sign[0]), .sign1(sign[1]),
      .ready0(ready0), .ready1(ready1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_be(mem_be),
      .mem_sign(mem_sign), .mem_dout(mem_dout), .busy(busy), .grant_id(grant_id)
    );

    assign mem_dout = dmem[mem_addr[7:2]];

    initial begin : run
      bit          act, own, last, gid, aft, idle, rst_now, hammer, win, e_we, e_sign;
      int          st, rdy;
      int          ps [2];
      int          scr [2];
      logic [31:0] e_addr, e_din, t_rd, v;
      logic [3:0]  e_be;
      logic [31:0] exp_rd [2];
      string       px;

      px = $sformatf("u%0d", g);
      for (int i = 0; i < 64; i++) begin
        v = $urandom;
        dmem[i] = v;
        rmem[i] = v;
      end
      dmem[4] = 32'h1234_5678;
      rmem[4] = 32'h1234_5678;
      rst = 1'b1;
      req = '0; we = '0; sign = '0;
      for (int p = 0; p < 2; p++) begin
        addr[p] = '0; wdata[p] = '0; be[p] = '0;
      end
      repeat (2) @(posedge clk);
      rst = 1'b0;
      act = 0; own = 0; last = 1; gid = 0; aft = 1;
      st = 0; rdy = 0; e_we = 0; e_sign = 0; e_addr = 0; e_din = 0; e_be = 0; t_rd = 0;
      exp_rd = '{32'd0, 32'd0};
      ps = '{0, 0};
      scr = '{0, 0};

      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (act && c == rdy && !e_we) exp_rd[own] = t_rd;
        check_eq({px, " busy"}, 32'(busy), 32'(act));
        check_eq({px, " ready0"}, 32'(ready0), 32'(act && c == rdy && !own));
        check_eq({px, " ready1"}, 32'(ready1), 32'(act && c == rdy && own));
        check_eq({px, " grant_id"}, 32'(grant_id), 32'(gid));
        check_eq({px, " rdata0"}, rdata0, exp_rd[0]);
        check_eq({px, " rdata1"}, rdata1, exp_rd[1]);
        check_eq({px, " mem_we"}, 32'(mem_we), 32'(act && c == st + 1 && e_we));
        if (act && c < rdy) begin
          check_eq({px, " mem_addr"}, mem_addr, e_addr);
          check_eq({px, " mem_din"}, mem_din, e_din);
          check_eq({px, " mem_be"}, 32'(mem_be), 32'(e_be));
          check_eq({px, " mem_sign"}, 32'(mem_sign), 32'(e_sign));
        end
        if (aft) begin
          check_eq({px, " rst mem_addr"}, mem_addr, 32'd0);
          check_eq({px, " rst mem_din"}, mem_din, 32'd0);
          check_eq({px, " rst mem_be"}, 32'(mem_be), 32'd0);
          check_eq({px, " rst mem_sign"}, 32'(mem_sign), 32'd0);
          aft = 0;
        end

        // The memory commits whatever the DUT strobes during this cycle.
        if (mem_we === 1'b1) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) dmem[mem_addr[7:2]][8*b +: 8] = mem_din[8*b +: 8];
        end

        idle = !act;
        if (act && c == rdy) begin
          ps[own] = 0;
          act = 0;
        end

        hammer  = (c >= 200 && c < 400);
        rst_now = (c >= 100) && !hammer && ($urandom_range(0, 39) == 0);

        for (int p = 0; p < 2; p++) begin
          if (ps[p] == 1 && act && own == p && !hammer && $urandom_range(0, 7) == 0) ps[p] = 2;
          if (ps[p] == 0 && (scr[p] < 2 - p || hammer || $urandom_range(0, 2) == 0)) begin
            ps[p] = 1;
            if (p == 0 && scr[0] < 2) begin
              we[0] = 1'b0; addr[0] = (scr[0] == 0) ? 32'h10 : 32'h20;
              wdata[0] = 32'd0; be[0] = 4'hf; sign[0] = 1'b0;
              scr[0]++;
            end else if (p == 1 && scr[1] < 1) begin
              we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'hDEAD_BEEF;
              be[1] = 4'hf; sign[1] = 1'b0;
              scr[1]++;
            end else begin
              we[p] = 1'($urandom); addr[p] = 32'($urandom_range(0, 255));
              wdata[p] = $urandom; be[p] = 4'($urandom); sign[p] = 1'($urandom);
            end
          end
          if (ps[p] == 1) begin
            req[p] = 1'b1;
          end else begin
            // Idle or abandoned ports wiggle their command lines; the arbiter must ignore them.
            req[p] = 1'b0;
            we[p] = 1'($urandom); addr[p] = $urandom; wdata[p] = $urandom;
            be[p] = 4'($urandom); sign[p] = 1'($urandom);
          end
        end

        rst = rst_now;
        if (rst_now) begin
          act = 0; gid = 0; last = 1; aft = 1;
          exp_rd = '{32'd0, 32'd0};
          ps = '{0, 0};
        end else if (idle && (req[0] || req[1])) begin
          win = (req[0] && req[1]) ? (Rr ? !last : 1'b0) : req[1];
          own = win; gid = win; last = win;
          st = c; rdy = c + Lat + 1; act = 1;
          e_we = we[win]; e_addr = addr[win]; e_din = wdata[win];
          e_be = be[win]; e_sign = sign[win];
          if (e_we) begin
            for (int b = 0; b < 4; b++)
              if (e_be[b]) rmem[e_addr[7:2]][8*b +: 8] = e_din[8*b +: 8];
          end else begin
            t_rd = rmem[e_addr[7:2]];
          end
        end
      end
      rst = 1'b0;
      req = '0;
      done[g] = 1'b1;
    end
  end

  initial begin : main
    bit ok;
    ok = 1'b0;
    fork
      begin
        wait (done[0] && done[1]);
        ok = 1'b1;
      end
      begin
        #500000;
      end
    join_any
    disable fork;
    check_eq("completion", 32'(ok), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single `Memory` instance between the multicycle CPU (port 0) and a secondary master such as a loader, DMA or debug port (port 1). It sits between the requesters and `Memory` in the MIPS top level. It serialises accesses, drives the memory address, data, write, byte-enable and sign lines for a fixed latency, and returns read data with a one-cycle ready pulse. Port 0's ready output drives the CPU's `MIO_ready` input.

## Interface
- `MEM_LAT`, default 1: memory access cycles per transaction; legal range 1..15.
- `ROUND_ROBIN`, default 1: 1 = round-robin on contention; 0 = fixed priority, port 0 wins.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0`, `req1` input 1 each: access request from port 0 (CPU) / port 1.
- `we0`, `we1` input 1 each: 1 = write, 0 = read.
- `addr0`, `addr1` input 32 each: byte address, passed through unchanged.
- `wdata0`, `wdata1` input 32 each: write data.
- `be0`, `be1` input 4 each: byte enables.
- `sign0`, `sign1` input 1 each: sign-extend control forwarded to memory.
- `ready0`, `ready1` output 1 each: one-cycle completion pulse.
- `rdata0`, `rdata1` output 32 each: registered read data per port.
- `mem_addr` output 32, `mem_din` output 32, `mem_we` output 1, `mem_be` output 4, `mem_sign` output 1: memory drive lines.
- `mem_dout` input 32: memory read data.
- `busy` output 1: high in BUSY and RESP.
- `grant_id` output 1: port owning the current or most recent transaction.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any `req` is high at the edge, select a winner, latch its we/addr/wdata/be/sign into the command register, load the counter with `MEM_LAT-1`, set `grant_id`, and go to BUSY.
  - With no request, stay in IDLE.
- **Arbitration**
  - A single request always wins.
  - When both request and `ROUND_ROBIN`=1, grant the port that is not `last_grant`.
  - When both request and `ROUND_ROBIN`=0, grant port 0.
  - `last_grant` updates on every grant and resets to 1, so port 0 wins the first tie.
- **BUSY**
  - `mem_addr`, `mem_din`, `mem_be` and `mem_sign` are driven from the command register for the whole of BUSY.
  - `mem_we` is high only in the first BUSY cycle of a write; it is 0 in all other cycles and for all reads.
  - The counter decrements each cycle. When it reaches 0 the FSM goes to RESP, and on a read `mem_dout` is captured into the granted port's `rdata` at that edge.
- **RESP**
  - The granted port's `ready` is high for exactly this one cycle; the other port's `ready` stays 0.
  - The FSM goes to IDLE unconditionally. Requests are not sampled in RESP.
- **Requester rule**
  - Hold req and the command stable until ready is seen.
  - Req still high in the IDLE cycle after RESP counts as a new request.
- **rdata**
  - Updated only on reads, and only for the granted port.
  - Holds its value otherwise, including across writes.
- **Boundary cases**
  - A requester that drops req mid-transaction does not cancel it: the access completes and ready still pulses.
  - Changes to the non-granted port's inputs during BUSY or RESP have no effect.
  - `rst` mid-transaction aborts it: FSM to IDLE, no ready pulse. A write whose `mem_we` cycle has already passed stays committed.

## Timing
- Reset values: state IDLE, `ready0/1`=0, `rdata0/1`=0, `mem_addr`=0, `mem_din`=0, `mem_we`=0, `mem_be`=4'b0000, `mem_sign`=0, `busy`=0, `grant_id`=0, `last_grant`=1.
- Latency: req sampled in cycle 0, then BUSY in cycles 1..`MEM_LAT`, then ready and valid `rdata` in cycle `MEM_LAT+1`.
- Throughput: at most one transaction per `MEM_LAT+2` cycles.
- All outputs are registered or decoded from state registers only; there is no combinational path from `req` to `ready`.

## Test plan
- **Single read:** `MEM_LAT`=1, `req0` with addr 0x10, memory word 0x12345678. Required: `mem_addr`=0x10 in cycle 1, `ready0` in cycle 2, `rdata0`=0x12345678, `ready1`=0.
- **Single write then read:** port 1 writes 0xDEADBEEF to 0x20 with be 4'b1111. Required: `mem_we` high for exactly one cycle. A following port 0 read of 0x20 returns 0xDEADBEEF, and `rdata1` is unchanged by the write.
- **Round-robin contention:** both reqs held continuously with `ROUND_ROBIN`=1 from reset. Required: grants alternate 0,1,0,1 and `ready` pulses every `MEM_LAT+2` cycles.
- **Fixed-priority contention:** same stimulus with `ROUND_ROBIN`=0. Required: port 1 never granted while `req0` is held.
- **Latency parameter:** `MEM_LAT`=3 read. Required: `busy` high for 4 cycles and `ready` in cycle 4.
- **Reset mid-access:** `rst` asserted in the second BUSY cycle. Required: no ready pulse, all outputs at reset values the next cycle, and the next request is served normally.
